regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised register file with an in-order write scoreboard for the next-generation pipelined datapath. It keeps the architectural registers and tracks which registers have a write in flight between issue (ID) and writeback (WB). It raises a stall on RAW and WAW hazards, forwards same-cycle writeback data to the read ports, and counts stall cycles. It sits in the ID stage: read ports feed the ID/EXE pipeline register, and the write port is driven from the MEM/WB pipeline register.

## Interface
- DSIZE, 32, data width
- ASIZE, 5, register address width; register count is 2**ASIZE
- NREAD, 2, number of read ports (1..4)
- CNTW, 16, width of the stall performance counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- raddr  in  NREAD*ASIZE  read addresses; port i occupies bits [i*ASIZE +: ASIZE]
- rden  in  NREAD  port i is used by the issuing instruction (hazard check enable)
- rdata  out  NREAD*DSIZE  read data, combinational, port i at [i*DSIZE +: DSIZE]
- iss_valid  in  1  instruction in ID wants to issue
- iss_wen  in  1  issuing instruction will write a register
- iss_waddr  in  ASIZE  destination of issuing instruction
- stall  out  1  hazard; ID must hold, do not issue
- wb_wen  in  1  writeback write enable
- wb_waddr  in  ASIZE  writeback address
- wb_wdata  in  DSIZE  writeback data
- flush  in  1  pipeline flush; clears all pending bits
- busy  out  2**ASIZE  pending-write vector (registered)
- err  out  1  sticky: writeback to a non-pending register
- stall_cnt  out  CNTW  saturating count of stalled cycles

## Operation
- Storage: 2**ASIZE x DSIZE registers plus one pending bit per register.
- Register 0 is hardwired to zero:
  - reads return 0;
  - writes are ignored;
  - it is never pending and never causes a stall.
- Read port i: if wb_wen and wb_waddr==raddr[i] and raddr[i]!=0, rdata[i] = wb_wdata (write-through bypass). Otherwise rdata[i] = the stored register value.
- Effective busy: busy_eff[r] = pending[r] & ~(wb_wen & wb_waddr==r). The writeback in the current cycle resolves the hazard.
- stall = iss_valid & ~flush & (any i: rden[i] & busy_eff[raddr[i]]  |  iss_wen & busy_eff[iss_waddr]). The second term is the WAW check.
- iss_fire = iss_valid & ~stall & ~flush.
- Pending update each cycle, applied in this order:
  1. clear pending[wb_waddr] if wb_wen;
  2. clear all pending bits if flush;
  3. set pending[iss_waddr] if iss_fire & iss_wen & iss_waddr!=0.
  - The set wins over a same-cycle clear of the same register.
- A writeback to a nonzero register whose pending bit is 0 sets err. err stays set until reset.
  - The data is still written.
  - Writebacks during flush are exempt from the err check.
- stall_cnt increments on every cycle stall=1 and saturates at 2**CNTW-1.
- flush does not block the writeback: data is still written.

## Timing
- Reset (rst=0, asynchronous):
  - all registers = 0, pending = 0, busy = 0;
  - err = 0, stall_cnt = 0;
  - stall = 0 because iss_valid is ignored while in reset.
- Register writes, pending bits, err and stall_cnt all update on the rising clk edge.
- rdata and stall are combinational from the current inputs and state. There is no added latency.
- Writeback-to-read latency: 0 cycles via bypass; the stored value is visible from the next cycle.
- Issue-to-busy latency: pending is set at the edge where iss_fire=1. busy shows it the following cycle.
- Reset deasserted mid-operation: the first edge after release behaves as a normal cycle from the all-zero state.

## Test plan
- Reset, then read r0..r31 on both ports -> all rdata=0, busy=0, err=0, stall_cnt=0.
- Issue iss_wen=1 to r5; next cycle issue with raddr0=5, rden0=1 -> stall=1. Hold for 3 cycles, then wb_wen r5 with data 0x1234 -> in that cycle stall=0, rdata0=0x1234 (bypass), iss_fire=1, stall_cnt=3.
- In one cycle: wb r7 (pending) and issue a new writer of r7 (WAW) -> no stall, pending[7]=1 after the edge, r7 holds the wb data.
- Issue a writer to r0, then read r0 with rden=1 -> never stalls, busy[0]=0. wb r0 with 0xFFFF -> r0 still reads 0.
- Set pending on r3 and r9, assert flush with iss_valid=1 -> stall=0, no issue. Next cycle busy=0. A wb to r3 during the flush cycle writes its data with err=0.
- wb to r12 with pending[12]=0 (no flush) -> err=1 and stays 1 across later cycles; r12 updated. Drive stall continuously with CNTW=4 for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with in-order write scoreboard for the ID stage.
// Tracks in-flight writes between issue and writeback, stalls on RAW/WAW
// hazards, bypasses same-cycle writeback data to the read ports and counts
// stalled cycles.

// One read port: bypassed read data plus its RAW hazard contribution.
module regfile_rd_port #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic [ASIZE-1:0]                   raddr,
  input  logic                               rden,
  input  logic [(1<<ASIZE)-1:0][DSIZE-1:0]   regs,
  input  logic [(1<<ASIZE)-1:0]              busy_eff,
  input  logic                               wb_wen,
  input  logic [ASIZE-1:0]                   wb_waddr,
  input  logic [DSIZE-1:0]                   wb_wdata,
  output logic [DSIZE-1:0]                   rdata,
  output logic                               hazard
);
  // Write-through bypass; r0 is never bypassed so it always reads zero.
  always_comb begin
    rdata  = regs[raddr];
    if (wb_wen && (wb_waddr == raddr) && (raddr != '0)) rdata = wb_wdata;
    hazard = rden & busy_eff[raddr];
  end
endmodule

module regfile_scoreboard #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int NREAD = 2,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ASIZE-1:0]  raddr,
  input  logic [NREAD-1:0]        rden,
  output logic [NREAD*DSIZE-1:0]  rdata,
  input  logic                    iss_valid,
  input  logic                    iss_wen,
  input  logic [ASIZE-1:0]        iss_waddr,
  output logic                    stall,
  input  logic                    wb_wen,
  input  logic [ASIZE-1:0]        wb_waddr,
  input  logic [DSIZE-1:0]        wb_wdata,
  input  logic                    flush,
  output logic [(1<<ASIZE)-1:0]   busy,
  output logic                    err,
  output logic [CNTW-1:0]         stall_cnt
);
  localparam int NREG = 1 << ASIZE;

  logic [NREG-1:0][DSIZE-1:0] regs_q, regs_d;
  logic [NREG-1:0]            pending_q, pending_d;
  logic                       err_q, err_d;
  logic [CNTW-1:0]            stall_cnt_q, stall_cnt_d;

  logic [NREG-1:0]  busy_eff;
  logic [NREAD-1:0] rd_hazard;
  logic             iss_fire;

  // A writeback landing this cycle resolves the hazard on its register.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy_eff[r] = pending_q[r] & ~(wb_wen && (wb_waddr == ASIZE'(r)));
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_rd_port #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_rd (
      .raddr    (raddr[g*ASIZE +: ASIZE]),
      .rden     (rden[g]),
      .regs     (regs_q),
      .busy_eff (busy_eff),
      .wb_wen   (wb_wen),
      .wb_waddr (wb_waddr),
      .wb_wdata (wb_wdata),
      .rdata    (rdata[g*DSIZE +: DSIZE]),
      .hazard   (rd_hazard[g])
    );
  end

  // Stall on any RAW read hazard or a WAW on the destination.
  always_comb begin
    stall    = iss_valid & ~flush & ((|rd_hazard) | (iss_wen & busy_eff[iss_waddr]));
    iss_fire = iss_valid & ~stall & ~flush;
  end

  // Next state: writeback, pending clear/flush/set in priority order, sticky err, counter.
  always_comb begin
    regs_d      = regs_q;
    pending_d   = pending_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    if (wb_wen && (wb_waddr != '0)) begin
      regs_d[wb_waddr] = wb_wdata;
      if (!pending_q[wb_waddr] && !flush) err_d = 1'b1;
    end
    if (wb_wen) pending_d[wb_waddr] = 1'b0;
    if (flush) pending_d = '0;
    if (iss_fire && iss_wen && (iss_waddr != '0)) pending_d[iss_waddr] = 1'b1;
    if (stall && (stall_cnt_q != {CNTW{1'b1}})) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q      <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = pending_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
endmodule
